// File: rtl/sprite_motion_ctrl_if.sv
// Request/done handshake between the sprite controller and the fill engine.
interface sprite_motion_ctrl_if;
  logic erase_req;
  logic draw_req;
  logic erase_done;
  logic draw_done;

  modport master (output erase_req, output draw_req, input erase_done, input draw_done);
  modport slave  (input erase_req, input draw_req, output erase_done, output draw_done);
endinterface

// File: rtl/sprite_motion_ctrl.sv
// Sprite position controller: erase -> move -> redraw through the fill engine,
// with a programmable wait between moves and wrap/clamp edge handling.
//
// state  | meaning
// RESET  | hold, track color_in, wait for load
// INDRAW | initial draw of the sprite
// IDLE   | wait for a non-cancelled direction request
// ERASE  | erase sprite at the old position
// MOVE   | one cycle, update x/y from the latched direction
// DRAW   | draw sprite at the new position
// WAIT   | pace moves, WAIT_CYCLES cycles
module sprite_motion_ctrl #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 156,
  parameter int Y_MAX       = 116,
  parameter int STEP        = 4,
  parameter int WAIT_CYCLES = 25_000_000,
  parameter int WRAP        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 up,
  input  logic                 down,
  input  logic                 left,
  input  logic                 right,
  input  logic [2:0]           color_in,
  sprite_motion_ctrl_if.master fill,
  output logic [X_W-1:0]       x,
  output logic [Y_W-1:0]       y,
  output logic [2:0]           color,
  output logic [3:0]           state,
  output logic                 busy
);

  localparam int               CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);
  localparam logic [X_W:0]     X_STEP   = (X_W + 1)'(STEP);
  localparam logic [X_W:0]     X_TOP    = (X_W + 1)'(X_MAX);
  localparam logic [Y_W:0]     Y_STEP   = (Y_W + 1)'(STEP);
  localparam logic [Y_W:0]     Y_TOP    = (Y_W + 1)'(Y_MAX);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_INDRAW = 4'd1,
    S_IDLE   = 4'd2,
    S_ERASE  = 4'd3,
    S_MOVE   = 4'd4,
    S_DRAW   = 4'd5,
    S_WAIT   = 4'd6
  } state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d, x_mv;
  logic [Y_W-1:0]   y_q, y_d, y_mv;
  logic [2:0]       color_q, color_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Deltas are two's complement: 01 = +1, 11 = -1, 00 = none.
  logic [1:0]       dx_q, dx_d, dy_q, dy_d;
  logic [1:0]       dx_in, dy_in;
  logic [X_W:0]     x_ext, x_inc;
  logic [Y_W:0]     y_ext, y_inc;

  assign dx_in = {1'b0, right} - {1'b0, left};
  assign dy_in = {1'b0, down}  - {1'b0, up};

  // Candidate position for the next MOVE, computed one bit wider to catch overflow.
  always_comb begin
    x_ext = {1'b0, x_q};
    x_inc = x_ext + X_STEP;
    y_ext = {1'b0, y_q};
    y_inc = y_ext + Y_STEP;
    x_mv  = x_q;
    y_mv  = y_q;
    if (dx_q == 2'b01) begin
      if (x_inc > X_TOP) x_mv = (WRAP != 0) ? '0 : X_TOP[X_W-1:0];
      else               x_mv = x_inc[X_W-1:0];
    end else if (dx_q == 2'b11) begin
      if (x_ext < X_STEP) x_mv = (WRAP != 0) ? X_TOP[X_W-1:0] : '0;
      else                x_mv = x_q - X_STEP[X_W-1:0];
    end
    if (dy_q == 2'b01) begin
      if (y_inc > Y_TOP) y_mv = (WRAP != 0) ? '0 : Y_TOP[Y_W-1:0];
      else               y_mv = y_inc[Y_W-1:0];
    end else if (dy_q == 2'b11) begin
      if (y_ext < Y_STEP) y_mv = (WRAP != 0) ? Y_TOP[Y_W-1:0] : '0;
      else                y_mv = y_q - Y_STEP[Y_W-1:0];
    end
  end

  // Next-state and datapath updates for the sequencing FSM.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    color_d = color_q;
    cnt_d   = cnt_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    case (state_q)
      S_RESET: begin
        color_d = color_in;
        if (load) state_d = S_INDRAW;
      end
      S_INDRAW: if (fill.draw_done) state_d = S_IDLE;
      S_IDLE: begin
        if ((dx_in != 2'b00) || (dy_in != 2'b00)) begin
          dx_d    = dx_in;
          dy_d    = dy_in;
          state_d = S_ERASE;
        end
      end
      S_ERASE: if (fill.erase_done) state_d = S_MOVE;
      S_MOVE: begin
        x_d     = x_mv;
        y_d     = y_mv;
        state_d = S_DRAW;
      end
      S_DRAW: begin
        if (fill.draw_done) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_LAST) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = S_RESET;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RESET;
      x_q     <= '0;
      y_q     <= '0;
      color_q <= '0;
      cnt_q   <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      color_q <= color_d;
      cnt_q   <= cnt_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign fill.erase_req = (state_q == S_ERASE);
  assign fill.draw_req  = (state_q == S_INDRAW) || (state_q == S_DRAW);
  assign busy           = (state_q != S_RESET) && (state_q != S_IDLE);
  assign state          = state_q;
  assign x              = x_q;
  assign y              = y_q;
  assign color          = color_q;

endmodule
